// File: rtl/shreg_seq.sv
// Serial shift sequencer: loads a parallel word on start, shifts it out LSB-first
// while shifting sin in at the MSB, then returns the captured word with a done pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet except the held dout
// SHIFT | one shift per edge; cnt counts down to the final shift
// DONE  | single-cycle done pulse, then back to IDLE unconditionally
module shreg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             sin,
    output logic             sout,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_len;

    // zero and oversize lengths both mean a full-width transfer
    always_comb begin
        eff_len = len;
        if (len == '0 || len > WIDTH_C) begin
            eff_len = WIDTH_C;
        end
    end

    assign sreg_nxt = {sin, sreg[WIDTH-1:1]};
    assign sout     = shift_en & sreg[0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            sreg     <= '0;
            cnt      <= '0;
            dout     <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            shift_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg     <= din;
                        cnt      <= eff_len;
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        shift_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        shift_en <= 1'b0;
                    end else begin
                        sreg <= sreg_nxt;
                        cnt  <= cnt - ONE_C;
                        if (cnt == ONE_C) begin
                            dout     <= sreg_nxt;
                            state    <= DONE;
                            done     <= 1'b1;
                            shift_en <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    shift_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shreg_seq.sv
// Bench for shreg_seq: transaction-level model checked every cycle, plus directed
// transfers with hand-computed serial streams and captured words.
module tb_shreg_seq;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       clr, start, abort, sin;
    logic [7:0] din;
    logic [3:0] len;
    wire        sout, shift_en, busy, done;
    wire  [7:0] dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shreg_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .din(din), .len(len),
        .abort(abort), .sin(sin), .sout(sout), .shift_en(shift_en),
        .busy(busy), .done(done), .dout(dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer is the saved word, a bit index and the list of received bits
    bit         m_act, m_done;
    int         m_k, m_n, m_rx;
    logic [7:0] m_din, m_dout;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_act = 0; m_done = 0; m_k = 0; m_n = 0; m_rx = 0;
            m_din = 8'h00; m_dout = 8'h00;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 0;
            end else begin
                m_rx = m_rx | (int'(sin) << m_k);
                m_k++;
                if (m_k == m_n) begin
                    m_dout = 8'((int'(m_din) >> m_n) | (m_rx << (W - m_n)));
                    m_act  = 0;
                    m_done = 1;
                end
            end
        end else if (start) begin
            m_act = 1;
            m_k   = 0;
            m_n   = (len == 4'd0 || int'(len) > W) ? W : int'(len);
            m_din = din;
            m_rx  = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_act | m_done);
        chk("shift_en", shift_en, m_act);
        chk("done", done, m_done);
        chk("sout", sout, m_act ? m_din[m_k] : 1'b0);
        chk("dout", dout, m_dout);
    end

    // Called at posedge+2 with the DUT idle; returns the observed serial stream.
    task automatic xfer(input logic [7:0] d, input logic [3:0] l, input logic s,
                        input int pulse_at, input int abort_at,
                        output logic [15:0] sbits, output int nsh,
                        output int edges, output bit got_done);
        sbits = '0; nsh = 0; edges = 0; got_done = 0;
        din = d; len = l; sin = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        while (edges < 20) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
            if (!busy) break;
            if (shift_en) begin
                sbits[nsh] = sout;
                nsh++;
            end
            @(posedge clk); #2;
            edges++;
            start = (edges == pulse_at);
            if (edges == pulse_at) din = 8'hFF;
            abort = (edges == abort_at - 1);
        end
        if (edges >= 20) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout: got no completion within 20 edges expected done or idle");
        end
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test expected finish");
        $fatal(1);
    end

    logic [15:0] sb;
    int          ns, ed;
    bit          gd;
    int          rises[$];
    logic        prev_busy;

    initial begin
        clr = 1'b1; start = 1'b0; abort = 1'b0; sin = 1'b0; din = 8'h00; len = 4'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 8'h00);
        repeat (4) begin
            @(posedge clk); #2;
            start = 1'($urandom); abort = 1'($urandom); sin = 1'($urandom);
            din = 8'($urandom); len = 4'($urandom);
        end
        #1;
        chk("rst_hold_busy", busy, 0);
        chk("rst_hold_shift_en", shift_en, 0);
        chk("rst_hold_done", done, 0);
        chk("rst_hold_sout", sout, 0);
        chk("rst_hold_dout", dout, 8'h00);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #2;
        clr = 1'b0;
        @(posedge clk); #2;

        xfer(8'hA5, 4'd8, 1'b0, -1, -1, sb, ns, ed, gd);
        chk("a5_sout_seq", sb[7:0], 8'hA5);
        chk("a5_shift_cnt", ns, 8);
        chk("a5_latency", ed, 8);
        chk("a5_done", gd, 1);
        chk("a5_dout", dout, 8'h00);

        xfer(8'h00, 4'd0, 1'b1, -1, -1, sb, ns, ed, gd);
        chk("rx_len0_dout", dout, 8'hFF);
        chk("rx_len0_shifts", ns, 8);

        xfer(8'h00, 4'd12, 1'b1, -1, -1, sb, ns, ed, gd);
        chk("rx_len12_dout", dout, 8'hFF);
        chk("rx_len12_shifts", ns, 8);
        chk("rx_len12_latency", ed, 8);

        xfer(8'h06, 4'd3, 1'b1, -1, -1, sb, ns, ed, gd);
        chk("part_sout_seq", sb[2:0], 3'b110);
        chk("part_dout", dout, 8'hE0);
        chk("part_latency", ed, 3);
        chk("part_shifts", ns, 3);

        xfer(8'hA5, 4'd8, 1'b0, 3, -1, sb, ns, ed, gd);
        chk("midstart_dout", dout, 8'h00);
        chk("midstart_latency", ed, 8);
        chk("midstart_sout_seq", sb[7:0], 8'hA5);

        xfer(8'hFF, 4'd8, 1'b1, -1, 4, sb, ns, ed, gd);
        chk("abort_no_done", gd, 0);
        chk("abort_idle_after_e4", ed, 4);
        chk("abort_shifts", ns, 4);
        chk("abort_dout_kept", dout, 8'h00);

        // start held high: accepts every n+2 edges
        din = 8'h06; len = 4'd3; sin = 1'b1; start = 1'b1;
        prev_busy = busy;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) rises.push_back(c);
            prev_busy = busy;
        end
        start = 1'b0;
        if (rises.size() >= 3) begin
            chk("held_start_gap1", rises[1] - rises[0], 5);
            chk("held_start_gap2", rises[2] - rises[1], 5);
        end else begin
            checks++;
            failures++;
            $display("FAIL held_start_accepts: got %0d accepts expected at least 3", rises.size());
        end
        repeat (8) @(posedge clk);
        #2;
        chk("held_start_dout", dout, 8'hE0);

        din = 8'hA5; len = 4'd8; sin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 clr = 1'b1;
        #1;
        chk("clr_mid_busy", busy, 0);
        chk("clr_mid_shift_en", shift_en, 0);
        chk("clr_mid_sout", sout, 0);
        chk("clr_mid_done", done, 0);
        chk("clr_mid_dout", dout, 8'h00);
        @(negedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #2;

        xfer(8'hA5, 4'd8, 1'b0, -1, -1, sb, ns, ed, gd);
        chk("post_clr_sout_seq", sb[7:0], 8'hA5);
        chk("post_clr_done", gd, 1);
        chk("post_clr_dout", dout, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
